// File: rtl/sipo_pkg.sv
// Shared types and sizing helpers for the sipo_rx serial receiver.
package sipo_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2
  } sipo_state_e;

  localparam int unsigned SIPO_WIDTH = 8;

  // Counter must hold the value WIDTH itself, hence the +1.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/sipo_shift.sv
// MSB-first shift register and bit counter: load restarts a word, shift appends at LSB.
module sipo_shift
  import sipo_pkg::*;
#(
  parameter int unsigned WIDTH = SIPO_WIDTH,
  parameter int unsigned CW    = cnt_width(SIPO_WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic             bit_in,
  output logic [WIDTH-1:0] word_nx,
  output logic [CW-1:0]    count_q
);

  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    count_d;

  always_comb begin
    shreg_d = shreg_q;
    count_d = count_q;
    if (load) begin
      shreg_d = {{(WIDTH-1){1'b0}}, bit_in};
      count_d = CW'(1);
    end else if (shift) begin
      shreg_d = {shreg_q[WIDTH-2:0], bit_in};
      count_d = count_q + CW'(1);
    end
  end

  // Next-cycle contents let the receiver capture a word on the edge that completes it.
  assign word_nx = shreg_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_q <= '0;
      count_q <= '0;
    end else begin
      shreg_q <= shreg_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/sipo_rx.sv
// Serial-in parallel-out receiver with double-buffered valid/ready output.
// Optional trailing even-parity bit enabled by defining SIPO_PARITY_EN.
module sipo_rx
  import sipo_pkg::*;
#(
  parameter int unsigned WIDTH = SIPO_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_in,
  input  logic             s_en,
  input  logic             s_start,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             overrun,
  input  logic             ovr_clr,
  output logic             parity_err
);

  localparam int unsigned CW = cnt_width(WIDTH);

  sipo_state_e      state_q, state_d;
  logic [WIDTH-1:0] word_nx;
  logic [CW-1:0]    count_q;
  logic             load, shift, done, word_perr, accept;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d, ovr_q, ovr_d, perr_q, perr_d;

  sipo_shift #(.WIDTH(WIDTH), .CW(CW)) u_shift (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .shift   (shift),
    .bit_in  (s_in),
    .word_nx (word_nx),
    .count_q (count_q)
  );

  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    shift     = 1'b0;
    done      = 1'b0;
    word_perr = 1'b0;
    if (s_en) begin
      if (s_start) begin
        load    = 1'b1;
        state_d = DATA;
      end else begin
        case (state_q)
          IDLE: ;
          DATA: begin
            shift = 1'b1;
            if (count_q == CW'(WIDTH - 1)) begin
`ifdef SIPO_PARITY_EN
              state_d = PAR;
`else
              done    = 1'b1;
              state_d = IDLE;
`endif
            end
          end
`ifdef SIPO_PARITY_EN
          PAR: begin
            done      = 1'b1;
            word_perr = (^word_nx) ^ s_in;
            state_d   = IDLE;
          end
`endif
          default: state_d = IDLE;
        endcase
      end
    end
  end

  always_comb begin
    accept  = valid_q & data_ready;
    data_d  = data_q;
    perr_d  = perr_q;
    valid_d = valid_q & ~accept;
    ovr_d   = ovr_q & ~ovr_clr;
    // A word completing on an accepting edge takes the slot being vacated.
    if (done) begin
      if (!valid_q || accept) begin
        data_d  = word_nx;
        perr_d  = word_perr;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      perr_q  <= perr_d;
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign overrun    = ovr_q;
  assign parity_err = perr_q;

endmodule

// File: tb/tb_sipo_rx.sv
// Self-checking bench for sipo_rx: frame-level reference model plus directed literal checks.
module tb_sipo_rx;

  localparam int unsigned W = 8;
`ifdef SIPO_PARITY_EN
  localparam int unsigned FL = W + 1;
`else
  localparam int unsigned FL = W;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         s_in = 1'b0, s_en = 1'b0, s_start = 1'b0;
  logic         data_ready = 1'b1, ovr_clr = 1'b0;
  logic [W-1:0] data_out;
  logic         data_valid, overrun, parity_err;

  int checks = 0;
  int errors = 0;

  sipo_rx #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .s_in       (s_in),
    .s_en       (s_en),
    .s_start    (s_start),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .overrun    (overrun),
    .ovr_clr    (ovr_clr),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: collect frame bits in arrival order, then apply the buffer rules.
  int unsigned m_nbits = 0;
  logic [W:0]  m_bits  = '0;
  bit          m_coll  = 1'b0;
  logic [W-1:0] m_data = '0;
  logic        m_valid = 1'b0, m_ovr = 1'b0, m_perr = 1'b0;

  always @(posedge clk or posedge rst) begin : model
    logic         fin;
    logic [W-1:0] w;
    logic         pe;
    if (rst) begin
      m_nbits = 0; m_bits = '0; m_coll = 1'b0;
      m_data = '0; m_valid = 1'b0; m_ovr = 1'b0; m_perr = 1'b0;
    end else begin
      fin = 1'b0;
      if (s_en) begin
        if (s_start) begin
          m_coll = 1'b1; m_nbits = 1; m_bits = {{W{1'b0}}, s_in};
        end else if (m_coll) begin
          m_bits = {m_bits[W-1:0], s_in};
          m_nbits++;
          if (m_nbits == FL) begin fin = 1'b1; m_coll = 1'b0; end
        end
      end
      if (FL == W) begin w = m_bits[W-1:0]; pe = 1'b0; end
      else begin w = m_bits[W:1]; pe = ^m_bits; end
      if (m_valid && data_ready) m_valid = 1'b0;
      if (ovr_clr) m_ovr = 1'b0;
      if (fin) begin
        if (!m_valid) begin m_data = w; m_valid = 1'b1; m_perr = pe; end
        else m_ovr = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    check("cyc_valid",  data_valid, m_valid);
    check("cyc_data",   data_out,   m_data);
    check("cyc_ovr",    overrun,    m_ovr);
    check("cyc_perr",   parity_err, m_perr);
  end

  task automatic tick(input logic en, input logic b, input logic st);
    @(negedge clk);
    s_en = en; s_in = b; s_start = st;
  endtask

  task automatic send_word(input logic [W-1:0] w, input int gap, input logic pflip,
                           input logic rdy_last);
    for (int i = 0; i < W; i++) begin
      tick(1'b1, w[W-1-i], i == 0);
      if (rdy_last && FL == W && i == W-1) data_ready = 1'b1;
      if (i != W-1 || FL > W) repeat (gap) tick(1'b0, 1'b0, 1'b0);
    end
    if (FL > W) begin
      tick(1'b1, (^w) ^ pflip, 1'b0);
      if (rdy_last) data_ready = 1'b1;
    end
  endtask

  task automatic idle_chk();
    tick(1'b0, 1'b0, 1'b0);
    #1;
  endtask

  initial begin
    #2 rst = 1'b1;
    repeat (2) tick(1'b0, 1'b0, 1'b0);
    #1;
    check("rst_data",  data_out,   8'h00);
    check("rst_valid", data_valid, 1'b0);
    check("rst_ovr",   overrun,    1'b0);
    check("rst_perr",  parity_err, 1'b0);
    rst = 1'b0;

    send_word(8'hBB, 0, 1'b0, 1'b0);
    idle_chk();
    check("single_valid", data_valid, 1'b1);
    check("single_data",  data_out,   8'hBB);
    check("single_ovr",   overrun,    1'b0);
    tick(1'b0, 1'b0, 1'b0);

    send_word(8'hBB, 3, 1'b0, 1'b0);
    idle_chk();
    check("gap_valid", data_valid, 1'b1);
    check("gap_data",  data_out,   8'hBB);
    tick(1'b0, 1'b0, 1'b0);

    data_ready = 1'b0;
    send_word(8'hBB, 0, 1'b0, 1'b0);
    send_word(8'h3C, 0, 1'b0, 1'b0);
    idle_chk();
    check("bp_data",  data_out,   8'hBB);
    check("bp_ovr",   overrun,    1'b1);
    check("bp_valid", data_valid, 1'b1);
    tick(1'b0, 1'b0, 1'b0);
    ovr_clr = 1'b1;
    tick(1'b0, 1'b0, 1'b0);
    ovr_clr = 1'b0;
    #1;
    check("bp_clr", overrun, 1'b0);
    data_ready = 1'b1;
    idle_chk();
    check("bp_drain_valid", data_valid, 1'b0);
    check("bp_drain_data",  data_out,   8'hBB);

    data_ready = 1'b0;
    send_word(8'hA5, 0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    send_word(8'h5A, 0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0);
    data_ready = 1'b0;
    #1;
    check("simul_valid", data_valid, 1'b1);
    check("simul_data",  data_out,   8'h5A);
    check("simul_ovr",   overrun,    1'b0);
    data_ready = 1'b1;
    tick(1'b0, 1'b0, 1'b0);

    send_word(8'h12, 0, 1'b0, 1'b0);
    send_word(8'h34, 0, 1'b0, 1'b0);
    send_word(8'h56, 0, 1'b0, 1'b0);
    send_word(8'h78, 0, 1'b0, 1'b0);
    idle_chk();
    check("b2b_data", data_out, 8'h78);
    check("b2b_ovr",  overrun,  1'b0);

    tick(1'b1, 1'b1, 1'b1);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    send_word(8'hF0, 0, 1'b0, 1'b0);
    idle_chk();
    check("resync_valid", data_valid, 1'b1);
    check("resync_data",  data_out,   8'hF0);

    data_ready = 1'b0;
    send_word(8'hBB, 0, 1'b0, 1'b0);
    send_word(8'h3C, 0, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b1);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_data",  data_out,   8'h00);
    check("mid_rst_valid", data_valid, 1'b0);
    check("mid_rst_ovr",   overrun,    1'b0);
    check("mid_rst_perr",  parity_err, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    data_ready = 1'b1;
    send_word(8'hC3, 0, 1'b0, 1'b0);
    idle_chk();
    check("post_rst_valid", data_valid, 1'b1);
    check("post_rst_data",  data_out,   8'hC3);

`ifdef SIPO_PARITY_EN
    send_word(8'hBB, 0, 1'b0, 1'b0);
    idle_chk();
    check("par_good_perr", parity_err, 1'b0);
    check("par_good_data", data_out,   8'hBB);
    send_word(8'hBB, 0, 1'b1, 1'b0);
    idle_chk();
    check("par_bad_perr",  parity_err, 1'b1);
    check("par_bad_data",  data_out,   8'hBB);
`else
    send_word(8'h96, 0, 1'b1, 1'b0);
    idle_chk();
    check("nopar_perr", parity_err, 1'b0);
    check("nopar_data", data_out,   8'h96);
`endif

    repeat (3) tick(1'b0, 1'b0, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sipo_rx.md
# sipo_rx

Serial-in, parallel-out receiver: the receiving end of the 8-bit shift-register serial link. It samples a strobed serial bit stream MSB-first, assembles WIDTH-bit words, and presents each word on a valid/ready parallel port. A completed word is double-buffered, so the next word can shift in while the consumer holds the current one. Sits between the serial link pins and the downstream parallel datapath.

## Interface
- WIDTH, 8, data bits per word (≥2)
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- s_in  input  1  serial data bit
- s_en  input  1  bit strobe; s_in sampled only on edges where s_en=1
- s_start  input  1  frame marker, qualified by s_en; marks first (MSB) bit of a word
- data_out  output  WIDTH  received word (bit WIDTH-1 = first bit received)
- data_valid  output  1  data_out holds an unconsumed word
- data_ready  input  1  consumer accepts word on edge where data_valid & data_ready
- overrun  output  1  sticky: a completed word was dropped
- ovr_clr  input  1  synchronous clear of overrun
- parity_err  output  1  parity status of data_out (see Configuration)

## Operation
- FSM states: IDLE, DATA, PAR (PAR only with SIPO_PARITY_EN).
- IDLE: s_en & !s_start bits ignored. s_en & s_start → shift reg ← s_in, bit count = 1, go DATA.
- DATA: each s_en edge shifts s_in in at LSB (shift left), count+1. When count reaches WIDTH: word complete (no parity) → IDLE; or → PAR.
- PAR: next s_en edge samples parity bit, word complete → IDLE.
- s_start & s_en in DATA or PAR: partial word discarded, that bit becomes new MSB, count = 1, stay/return DATA. No error flagged.
- s_en=0: no state change, shift reg and count hold (gaps of any length allowed).
- Word complete: if output buffer empty, or being accepted on the same edge → data_out ← word, data_valid=1. Otherwise word dropped, data_out unchanged, overrun ← 1.
- Acceptance with no new word on the same edge → data_valid ← 0; data_out holds last value.
- overrun: set has priority over ovr_clr on the same edge.
- data_out stable while data_valid=1 and not accepted.

## Timing
- Reset (async, immediate): state IDLE, count 0, shift reg 0, data_out 0, data_valid 0, overrun 0, parity_err 0.
- Latency: data_valid rises in the cycle after the edge sampling the last bit (last data bit, or parity bit when enabled).
- Back-to-back words at full rate (s_en=1 every cycle, s_start every WIDTH cycles) sustained with no loss when data_ready=1.
- Reset mid-word or with data_valid=1: partial word and buffered word lost; no output pulse.
- All outputs registered; no combinational path from inputs to outputs.

## Configuration
- SIPO_PARITY_EN defined: one parity bit follows the WIDTH data bits; even parity over data+parity bit. parity_err registered with data_out (1 = mismatch), valid only while data_valid=1; word still delivered.
- Not defined: no PAR state, word completes after WIDTH bits, parity_err constant 0 (port retained).

## Structure
- Package sipo_pkg: state enum type (IDLE, DATA, PAR), default WIDTH constant, bit-count width function/constant ($clog2(WIDTH+1)).
- Sub-module sipo_shift: shift register + bit counter (load-on-start, shift-on-enable, count output); sipo_rx holds FSM, output buffer, handshake, overrun, parity.

## Test plan
- Single word: s_start on first bit, send 1,0,1,1,1,0,1,1 with s_en=1 each cycle, data_ready=1 → data_valid high one cycle after 8th bit, data_out=8'hBB, overrun=0.
- Gaps: same 0xBB with s_en low 3 cycles between each bit → identical result; no early data_valid.
- Backpressure: data_ready=0, send 8'hBB then 8'h3C → data_out stays 8'hBB, overrun=1; ovr_clr pulse → overrun=0; data_ready=1 → data_valid falls next cycle.
- Simultaneous: 8'hA5 buffered, 8'h5A completes on the edge data_ready=1 → data_valid stays 1, data_out=8'h5A, overrun=0.
- Resync/reset: s_start after 4 bits, then 8 bits of 8'hF0 → data_out=8'hF0; separately rst mid-word → all outputs 0 immediately, next full word received correctly.
- With SIPO_PARITY_EN: 8'hBB + parity 0 → parity_err=0; 8'hBB + parity 1 → parity_err=1, data_out=8'hBB in both cases.
